pipe_hazard_ctrl: RTL
=====================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter LU_STALL, default 1, load-use bubble cycles inserted, legal 1..3.
REQ-002 SHALL have ports: cpu_clk  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have: cpu_rst_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have: rs1_ID, rs2_ID  in  5 each  source registers of the instruction in ID.
REQ-005 SHALL have: rs1_used_ID, rs2_used_ID  in  1 each  the ID instruction reads rs1/rs2.
REQ-006 SHALL have: wR_EX, wR_MEM, wR_WB  in  5 each  destination registers in EX/MEM/WB.
REQ-007 SHALL have: rf_we_EX, rf_we_MEM, rf_we_WB  in  1 each  register-file write enable per stage.
REQ-008 SHALL have: ld_EX  in  1  the EX instruction is a load.
REQ-009 SHALL have: br_taken_EX  in  1  branch/jump redirect resolved in EX.
REQ-010 SHALL have: pc_stall, if_id_stall  out  1 each  hold the PC and the IF/ID register.
REQ-011 SHALL have: if_id_flush, id_ex_flush  out  1 each  clear the register to a bubble next edge.
REQ-012 SHALL have: fwd_a_sel, fwd_b_sel  out  2 each  ID operand source: 0 regfile, 1 EX, 2 MEM, 3 WB.
REQ-013 SHALL have: hz_busy  out  1  FSM not in RUN.

Function
REQ-014 SHALL define hit_S(x) = rf_we_S && wR_S != 0 && wR_S == rsx_ID && rsx_used_ID, for S in {EX, MEM, WB}.
REQ-015 SHALL implement FSM states RUN, STALL, FLUSH, plus a 2-bit down-counter cnt.
REQ-016 RUN: br_taken_EX -> if_id_flush=id_ex_flush=1 that cycle, next state FLUSH.
REQ-017 RUN: otherwise a stall condition (REQ-023/REQ-026) -> pc_stall=if_id_stall=id_ex_flush=1 that cycle; cnt<=LU_STALL-1; next state STALL if LU_STALL>1, else RUN.
REQ-018 STALL: pc_stall=if_id_stall=id_ex_flush=1; cnt decrements; exits to RUN in the cycle cnt==0.
REQ-019 FLUSH: lasts exactly one cycle with no outputs asserted, then RUN; it masks a stale hazard from the killed ID slot.
REQ-020 br_taken_EX in any state SHALL win over a stall: flushes asserted, stalls deasserted, cnt cleared, next state FLUSH.
REQ-021 Outputs SHALL be combinational from the state, cnt and the current inputs, so the stall takes effect on the same edge as detection.
REQ-022 Register 0 SHALL never cause a stall or forwarding.

Configuration
REQ-023 With HAZARD_FWD_EN defined: stall condition = ld_EX && (hit_EX(1) || hit_EX(2)).
REQ-024 With HAZARD_FWD_EN defined: fwd_x_sel uses priority EX > MEM > WB (first hit wins), else 0.
REQ-025 With HAZARD_FWD_EN defined: fwd_x_sel SHALL be 0 while pc_stall=1.
REQ-026 Without HAZARD_FWD_EN: stall condition = any hit_EX or hit_MEM on either operand.
REQ-027 Without HAZARD_FWD_EN: the stall holds in RUN while the condition persists and LU_STALL is ignored.
REQ-028 Without HAZARD_FWD_EN: fwd_a_sel=fwd_b_sel=0, and the register file is relied on for write-before-read in WB.

Reset
REQ-029 cpu_rst_n low SHALL immediately force state RUN and cnt 0, independent of the clock.
REQ-030 While cpu_rst_n is low, all stall/flush outputs, hz_busy and fwd_x_sel SHALL be 0.
REQ-031 Reset asserted mid-STALL or mid-FLUSH SHALL abort the sequence, with no residual stall after release.
REQ-032 The first edge after release SHALL evaluate hazards normally.

Verification
REQ-033 FWD_EN, LU_STALL=1: ld x5 in EX, ID reads rs1=x5 -> one cycle pc_stall=if_id_stall=id_ex_flush=1, then fwd_a_sel=2.
REQ-034 FWD_EN: x7 written in EX and in MEM, ID reads rs2=x7 -> fwd_b_sel=1; with only WB writing x7 -> fwd_b_sel=3; x0 -> 0.
REQ-035 FWD_EN, LU_STALL=3: load-use -> stall exactly 3 cycles; hz_busy high for cycles 2-3.
REQ-036 Load-use and br_taken_EX in the same cycle -> if_id_flush=id_ex_flush=1, pc_stall=0, then FLUSH for 1 cycle, then RUN.
REQ-037 No FWD_EN: add x3 in EX, ID reads x3 -> stall 2 cycles (EX, then MEM) and release when x3 reaches WB; fwd sels stay 0.
REQ-038 Pulse cpu_rst_n low during cycle 2 of a 3-cycle stall -> outputs 0 asynchronously, and the state after release is RUN with no stall.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for the ID stage: load-use / RAW stalls, branch flushes and
// operand-forward selects. Forwarding is built only when HAZARD_FWD_EN is defined.
module pipe_hazard_ctrl #(
    parameter int LU_STALL = 1
) (
    input  logic       cpu_clk,
    input  logic       cpu_rst_n,
    input  logic [4:0] rs1_ID,
    input  logic [4:0] rs2_ID,
    input  logic       rs1_used_ID,
    input  logic       rs2_used_ID,
    input  logic [4:0] wR_EX,
    input  logic [4:0] wR_MEM,
    input  logic [4:0] wR_WB,
    input  logic       rf_we_EX,
    input  logic       rf_we_MEM,
    input  logic       rf_we_WB,
    input  logic       ld_EX,
    input  logic       br_taken_EX,
    output logic       pc_stall,
    output logic       if_id_stall,
    output logic       if_id_flush,
    output logic       id_ex_flush,
    output logic [1:0] fwd_a_sel,
    output logic [1:0] fwd_b_sel,
    output logic       hz_busy,
    output logic [1:0] hz_state,
    output logic [5:0] hz_hit,
    output logic       hz_ld_use
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    localparam logic [1:0] CNT_LOAD = 2'(LU_STALL - 1);
`ifdef HAZARD_FWD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    state_t     state;
    logic [1:0] cnt;
    logic       stall_cond;
    logic       hit_ex_a, hit_ex_b, hit_mem_a, hit_mem_b, hit_wb_a, hit_wb_b;

    // Register 0 is hard-wired, so it never matches a producer.
    assign hit_ex_a  = rf_we_EX  && (wR_EX  != 5'd0) && (wR_EX  == rs1_ID) && rs1_used_ID;
    assign hit_ex_b  = rf_we_EX  && (wR_EX  != 5'd0) && (wR_EX  == rs2_ID) && rs2_used_ID;
    assign hit_mem_a = rf_we_MEM && (wR_MEM != 5'd0) && (wR_MEM == rs1_ID) && rs1_used_ID;
    assign hit_mem_b = rf_we_MEM && (wR_MEM != 5'd0) && (wR_MEM == rs2_ID) && rs2_used_ID;
    assign hit_wb_a  = rf_we_WB  && (wR_WB  != 5'd0) && (wR_WB  == rs1_ID) && rs1_used_ID;
    assign hit_wb_b  = rf_we_WB  && (wR_WB  != 5'd0) && (wR_WB  == rs2_ID) && rs2_used_ID;

    assign hz_hit    = {hit_wb_b, hit_wb_a, hit_mem_b, hit_mem_a, hit_ex_b, hit_ex_a};
    assign hz_ld_use = ld_EX && (hit_ex_a || hit_ex_b);
    assign hz_state  = state;

    always_comb begin
        stall_cond = 1'b0;
`ifdef HAZARD_FWD_EN
        stall_cond = ld_EX && (hit_ex_a || hit_ex_b);
`else
        stall_cond = hit_ex_a || hit_ex_b || hit_mem_a || hit_mem_b;
`endif
    end

    // Outputs are combinational so a stall lands on the same edge it is seen.
    always_comb begin
        pc_stall    = 1'b0;
        if_id_stall = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        hz_busy     = 1'b0;
        if (cpu_rst_n) begin
            hz_busy = (state != ST_RUN);
            if (br_taken_EX) begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if ((state == ST_STALL) || ((state == ST_RUN) && stall_cond)) begin
                pc_stall    = 1'b1;
                if_id_stall = 1'b1;
                id_ex_flush = 1'b1;
            end
        end
    end

    always_comb begin
        fwd_a_sel = 2'd0;
        fwd_b_sel = 2'd0;
`ifdef HAZARD_FWD_EN
        // The FLUSH cycle carries a killed ID slot, so nothing is forwarded.
        if (cpu_rst_n && !pc_stall && (state != ST_FLUSH)) begin
            if (hit_ex_a)       fwd_a_sel = 2'd1;
            else if (hit_mem_a) fwd_a_sel = 2'd2;
            else if (hit_wb_a)  fwd_a_sel = 2'd3;
            if (hit_ex_b)       fwd_b_sel = 2'd1;
            else if (hit_mem_b) fwd_b_sel = 2'd2;
            else if (hit_wb_b)  fwd_b_sel = 2'd3;
        end
`endif
    end

    // cnt counts the remaining STALL cycles; it reaches 0 on the exit edge.
    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state <= ST_RUN;
            cnt   <= 2'd0;
        end else if (br_taken_EX) begin
            state <= ST_FLUSH;
            cnt   <= 2'd0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (stall_cond && FWD_EN && (LU_STALL > 1)) begin
                        state <= ST_STALL;
                        cnt   <= CNT_LOAD;
                    end
                end
                ST_STALL: begin
                    if (cnt <= 2'd1) begin
                        state <= ST_RUN;
                        cnt   <= 2'd0;
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                ST_FLUSH: begin
                    state <= ST_RUN;
                end
                default: begin
                    state <= ST_RUN;
                    cnt   <= 2'd0;
                end
            endcase
        end
    end

endmodule
